// File: rtl/uart_mult_pkg.sv
// Shared types and constants for the UART multiply frame controller.
package uart_mult_pkg;

    // Byte that opens every request frame.
    localparam logic [7:0] MULT_FRAME_HDR = 8'hA5;

    // A frame is the header followed by the two operands.
    localparam int FRAME_BYTES = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_MULT,
        ST_TX_LOAD,
        ST_TX_ACK,
        ST_TX_WAIT
    } mult_frame_state_t;

endpackage

// File: rtl/uart_mult_frame_ctrl_if.sv
// Byte-level links to the UART receiver and transmitter, plus the status
// signals of the multiply frame controller.
interface uart_mult_frame_ctrl_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        frame_err;

    // Environment side: the UART receiver/transmitter and any status consumer.
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_start, result, result_valid, busy, frame_err
    );

    // Controller side.
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_start, result, result_valid, busy, frame_err
    );

endinterface

// File: rtl/uart_mult_frame_ctrl_seq_mult.sv
// 8x8 unsigned shift-add multiplier. The start edge performs the first of
// eight iterations, so done pulses exactly 8 cycles after the start cycle
// with product already final.
module seq_mult_8x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        done
);

    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        done_q, done_d;

    // One shift-add iteration per cycle; start loads operands and does iteration 0.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = b[0] ? {8'h00, a} : 16'h0000;
            mcand_d  = {7'h00, a, 1'b0};
            mplier_d = {1'b0, b[7:1]};
            cnt_d    = 3'd1;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[14:0], 1'b0};
            mplier_d = {1'b0, mplier_q[7:1]};
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign product = acc_q;
    assign done    = done_q;

endmodule

// File: rtl/uart_mult_frame_ctrl.sv
// Parses {HEADER, A, B} frames from the UART receiver, multiplies A*B and
// returns the 16-bit product to the UART transmitter, high byte first.
// Bad headers and stalled frames/handshakes raise a one-cycle frame_err.
module uart_mult_frame_ctrl
    import uart_mult_pkg::*;
#(
    parameter logic [7:0] HEADER         = MULT_FRAME_HDR,
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    localparam int        TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clk_int,
    input  logic                  uart_reset,
    uart_mult_frame_ctrl_if.slave bus
);

    mult_frame_state_t state_q, state_d;
    logic [7:0]        a_q, a_d;
    logic              byte_sel_q, byte_sel_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]       result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic              to_expired;
    logic              mult_start;
    logic [15:0]       mult_product;
    logic              mult_done;

    // B goes straight to the multiplier on its arrival cycle.
    assign mult_start = (state_q == ST_GET_B) && bus.rx_valid;

    seq_mult_8x8 u_mult (
        .clk     (clk_int),
        .rst     (uart_reset),
        .start   (mult_start),
        .a       (a_q),
        .b       (bus.rx_data),
        .product (mult_product),
        .done    (mult_done)
    );

    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Frame parsing and transmit handshake: next state and registered outputs.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        byte_sel_d     = byte_sel_q;
        result_d       = result_q;
        tx_data_d      = tx_data_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        tx_start_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == HEADER) begin
                        state_d = ST_GET_A;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                // An arriving byte takes priority over a coincident expiry.
                if (bus.rx_valid) begin
                    a_d     = bus.rx_data;
                    state_d = ST_GET_B;
                end else if (to_expired) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            ST_GET_B: begin
                if (bus.rx_valid) begin
                    state_d = ST_MULT;
                end else if (to_expired) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            ST_MULT: begin
                if (mult_done) begin
                    result_d       = mult_product;
                    result_valid_d = 1'b1;
                    byte_sel_d     = 1'b0;
                    state_d        = ST_TX_LOAD;
                end
            end
            ST_TX_LOAD: begin
                if (bus.tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_sel_q ? result_q[7:0] : result_q[15:8];
                    state_d    = ST_TX_ACK;
                end
            end
            ST_TX_ACK: begin
                // The transmitter dropping ready means it took the byte.
                if (!bus.tx_ready) begin
                    state_d = ST_TX_WAIT;
                end else if (to_expired) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            ST_TX_WAIT: begin
                if (bus.tx_ready) begin
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = ST_TX_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timeout counter: restarts on every state change, runs only while waiting on a peer.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if (state_q inside {ST_GET_A, ST_GET_B, ST_TX_ACK}) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            state_q        <= ST_IDLE;
            a_q            <= '0;
            byte_sel_q     <= 1'b0;
            to_cnt_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            byte_sel_q     <= byte_sel_d;
            to_cnt_q       <= to_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
        end
    end

    assign bus.tx_data      = tx_data_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule
